// File: rtl/p_hardisc.sv
// Shared AHB-Lite constants and request bundle for the core bus arbiter.
// Exports HTRANS codes, master indices and the ahb_areq address-phase struct.
package p_hardisc;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam int MST_LSU   = 0;
  localparam int MST_FETCH = 1;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
  } ahb_areq;

endpackage

// File: rtl/ahb_arb_pend.sv
// Per-master pending address-phase register for the AHB arbiter.
// Ports: clk_i/rst_i, cap_i (store req_i), clr_i (drop), valid_o, req_o.
module ahb_arb_pend
  import p_hardisc::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    cap_i,
  input  logic    clr_i,
  input  ahb_areq req_i,
  output logic    valid_o,
  output ahb_areq req_o
);

  logic    v_q, v_d;
  ahb_areq r_q, r_d;

  always_comb begin
    v_d = v_q;
    r_d = r_q;
    if (clr_i) begin
      v_d = 1'b0;
    end
    if (cap_i) begin
      v_d = 1'b1;
      r_d = req_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q <= 1'b0;
      r_q <= '0;
    end else begin
      v_q <= v_d;
      r_q <= r_d;
    end
  end

  assign valid_o = v_q;
  assign req_o   = r_q;

endmodule

// File: rtl/ahb_arbiter.sv
// Two-to-one AHB-Lite arbiter: LSU (0) and fetch (1) share one manager port.
// Ports: s_*_i[2]/s_*_o[2] per-master side, s_h*_o/s_h*_i manager side,
// s_dp_owner_o one-hot data-phase owner. Single transfers only.
module ahb_arbiter
  import p_hardisc::*;
#(
  parameter int ARB_RR     = 0,
  parameter int STARVE_MAX = 8
) (
  input  logic        s_clk_i,
  input  logic        s_rst_i,
  input  logic [31:0] s_haddr_i  [2],
  input  logic [1:0]  s_htrans_i [2],
  input  logic        s_hwrite_i [2],
  input  logic [2:0]  s_hsize_i  [2],
  input  logic [31:0] s_hwdata_i [2],
  output logic        s_hready_o [2],
  output logic [31:0] s_hrdata_o [2],
  output logic        s_hresp_o  [2],
  output logic [31:0] s_haddr_o,
  output logic [1:0]  s_htrans_o,
  output logic        s_hwrite_o,
  output logic [2:0]  s_hsize_o,
  output logic [31:0] s_hwdata_o,
  output logic [2:0]  s_hburst_o,
  output logic [3:0]  s_hprot_o,
  output logic        s_hmastlock_o,
  input  logic        s_hready_i,
  input  logic        s_hresp_i,
  input  logic [31:0] s_hrdata_i,
  output logic [1:0]  s_dp_owner_o
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [1:0]    live, cand, gnt, cap, pend_v;
  logic [1:0]    dp_own_q, dp_own_d;
  logic          rr_last_q, rr_last_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          pick_fetch;
  ahb_areq       live_req [2];
  ahb_areq       pend_req [2];
  ahb_areq       win_req, bus_req;
  ahb_areq       last_q, last_d;
  logic          unused_htrans;

  assign unused_htrans = s_htrans_i[0][0] ^ s_htrans_i[1][0];

  // A master with an owned data phase follows the bus; a master
  // holding a pending entry is stalled until that entry issues.
  always_comb begin
    for (int m = 0; m < 2; m++) begin
      s_hready_o[m] = dp_own_q[m] ? s_hready_i : ~pend_v[m];
      s_hrdata_o[m] = s_hrdata_i;
      s_hresp_o[m]  = dp_own_q[m] & s_hresp_i;
    end
  end

  always_comb begin
    for (int m = 0; m < 2; m++) begin
      live[m]     = s_htrans_i[m][1] & s_hready_o[m];
      live_req[m] = '{addr:  s_haddr_i[m],
                      write: s_hwrite_i[m],
                      size:  s_hsize_i[m]};
    end
    cand = pend_v | live;
  end

  // rr_last_q = 1 means fetch won last, so LSU is favoured next.
  assign pick_fetch = (ARB_RR != 0) ? ~rr_last_q
                                    : (starve_q == STARVE_LIM);

  always_comb begin
    gnt = 2'b00;
    if (s_hready_i && !s_rst_i) begin
      unique case (cand)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = pick_fetch ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Any accepted address phase that did not win is parked,
  // including one accepted while the bus is stalled.
  assign cap = live & ~gnt;

  for (genvar m = 0; m < 2; m++) begin : g_pend
    ahb_arb_pend u_pend (
      .clk_i   (s_clk_i),
      .rst_i   (s_rst_i),
      .cap_i   (cap[m]),
      .clr_i   (gnt[m]),
      .req_i   (live_req[m]),
      .valid_o (pend_v[m]),
      .req_o   (pend_req[m])
    );
  end

  always_comb begin
    if (gnt[MST_FETCH]) begin
      win_req = pend_v[MST_FETCH] ? pend_req[MST_FETCH]
                                  : live_req[MST_FETCH];
    end else begin
      win_req = pend_v[MST_LSU] ? pend_req[MST_LSU]
                                : live_req[MST_LSU];
    end
  end

  // Without a grant the address bus keeps the last issued phase.
  assign bus_req = (|gnt) ? win_req : last_q;

  assign s_haddr_o     = bus_req.addr;
  assign s_hwrite_o    = bus_req.write;
  assign s_hsize_o     = bus_req.size;
  assign s_htrans_o    = (|gnt) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign s_hburst_o    = 3'b000;
  assign s_hprot_o     = 4'b0000;
  assign s_hmastlock_o = 1'b0;
  assign s_dp_owner_o  = dp_own_q;

  always_comb begin
    unique case (1'b1)
      dp_own_q[MST_LSU]:   s_hwdata_o = s_hwdata_i[MST_LSU];
      dp_own_q[MST_FETCH]: s_hwdata_o = s_hwdata_i[MST_FETCH];
      default:             s_hwdata_o = '0;
    endcase
  end

  always_comb begin
    dp_own_d  = s_hready_i ? gnt : dp_own_q;
    last_d    = (|gnt) ? win_req : last_q;
    rr_last_d = rr_last_q;
    if (gnt[MST_FETCH]) begin
      rr_last_d = 1'b1;
    end else if (gnt[MST_LSU]) begin
      rr_last_d = 1'b0;
    end
    starve_d = starve_q;
    if (gnt[MST_FETCH]) begin
      starve_d = '0;
    end else if (s_hready_i && cand[MST_FETCH]
                 && starve_q != STARVE_LIM) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge s_clk_i) begin
    if (s_rst_i) begin
      dp_own_q  <= 2'b00;
      rr_last_q <= 1'b1;
      starve_q  <= '0;
      last_q    <= '0;
    end else begin
      dp_own_q  <= dp_own_d;
      rr_last_q <= rr_last_d;
      starve_q  <= starve_d;
      last_q    <= last_d;
    end
  end

endmodule

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
- Shares one AHB-Lite manager port between two requesters: master 0 = EX-stage LSU data port, master 1 = instruction fetch.
- Sits between the core bus ports and the system interconnect.
- Each requester sees a private AHB-Lite subordinate interface. A losing address phase is captured in a per-master pending register; that master is then stalled through its private hready until its transfer completes.
- Only single transfers are supported (NONSEQ/IDLE). hburst, hprot and hmastlock are constant.

Parameters:
- ARB_RR, 0: arbitration mode. 0 = fixed priority to master 0; 1 = round-robin between contenders.
- STARVE_MAX, 8: cycles a pending request may lose before it is forced to win (fixed-priority mode only); counter width $clog2(STARVE_MAX+1).

Ports:
- s_clk_i  in  1  clock.
- s_rst_i  in  1  synchronous, active-high reset.
- s_haddr_i[2]  in  32  per-master address; index 0 = LSU, 1 = fetch.
- s_htrans_i[2]  in  2  per-master transfer type.
- s_hwrite_i[2]  in  1  per-master write indicator.
- s_hsize_i[2]  in  3  per-master transfer size.
- s_hwdata_i[2]  in  32  per-master write data (data phase).
- s_hready_o[2]  out  1  per-master ready.
- s_hrdata_o[2]  out  32  per-master read data.
- s_hresp_o[2]  out  1  per-master error response.
- s_haddr_o  out  32  manager address.
- s_htrans_o  out  2  manager transfer type.
- s_hwrite_o  out  1  manager write indicator.
- s_hsize_o  out  3  manager transfer size.
- s_hwdata_o  out  32  manager write data.
- s_hburst_o  out  3  constant 0.
- s_hprot_o  out  4  constant 0.
- s_hmastlock_o  out  1  constant 0.
- s_hready_i  in  1  interconnect ready.
- s_hresp_i  in  1  interconnect error response.
- s_hrdata_i  in  32  interconnect read data.
- s_dp_owner_o  out  2  one-hot owner of the current data phase (debug/verification).

Behaviour:
- Live request m: s_htrans_i[m][1] & s_hready_o[m]. The address is accepted at this edge.
- Candidate m: pend_v[m], or a live request from m.
- When s_hready_i=1, the arbiter selects a winner among candidates (combinational, same cycle). s_haddr_o/s_hwrite_o/s_hsize_o come from the winner's pending register if pend_v, else from its live inputs. s_htrans_o=NONSEQ if a winner exists, else IDLE.
- When s_hready_i=0: no new grant. Manager address outputs stay at the previously issued values; s_htrans_o=IDLE unless a transfer is already being held.
- Winner at an edge with s_hready_i=1:
  - dp_own <= winner, else none.
  - winner's pend_v clears.
  - a live loser is captured: pend_v<=1, addr/write/size stored.
- Pending register ownership: pend_v[m]=1 only via a captured loss. At most one pending entry per master, because s_hready_o[m]=0 while pend_v[m]=1.
- s_hready_o[m]:
  - = s_hready_i if dp_own==m;
  - else 0 if pend_v[m];
  - else 1.
- s_hwdata_o = s_hwdata_i[dp_own]; 0 when there is no owner.
- s_hrdata_o[m] = s_hrdata_i for every m.
- s_hresp_o[m] = s_hresp_i only when dp_own==m, else 0. An error's two cycles pass through unchanged; the other master's pending entry is unaffected.
- Fixed priority (ARB_RR=0):
  - master 0 wins contention;
  - starve counter increments each cycle pend_v[1] loses with s_hready_i=1;
  - at STARVE_MAX, master 1 wins the next grant slot;
  - counter clears when master 1 wins.
- Round-robin (ARB_RR=1):
  - rr_last records the last winner on contention; the other master wins the next contention;
  - uncontested grants also update rr_last.
- Latency: an uncontested live request is on the manager bus the same cycle, zero added cycles. A losing request is issued at the first slot it wins.
- Reset (any cycle, including mid-transfer):
  - pend_v=0, dp_own=none, starve counter 0, rr_last=1 (master 0 wins the first contention);
  - s_htrans_o=IDLE, s_hready_o={1,1}, s_hresp_o=0;
  - in-flight transfers are abandoned.

Decomposition:
- Add to p_hardisc:
  - HTRANS_IDLE=2'b00, HTRANS_NONSEQ=2'b10;
  - MST_LSU=0, MST_FETCH=1;
  - typedef ahb_areq (addr, write, size).
- One sub-module, ahb_arb_pend: per-master pending register with capture, clear and valid flag. Instantiated twice.

Test Plan:
- Single LSU read to 0x1000, fetch idle -> s_haddr_o=0x1000 and NONSEQ same cycle; s_hrdata_i=0xCAFE0001 returns on s_hrdata_o[0] with s_hready_o[0]=1 next cycle.
- Both request same cycle (LSU 0x2000, fetch 0x0100), ARB_RR=0 -> 0x2000 issued first; fetch pending with s_hready_o[1]=0; 0x0100 issued next cycle; s_dp_owner_o=01 then 10.
- LSU write 0x3000 data 0xDEADBEEF with s_hready_i held low 3 cycles -> s_hwdata_o stable 0xDEADBEEF; s_hready_o[0]=0 for 3 cycles; fetch pending not issued until ready returns.
- Continuous LSU requests plus one fetch, ARB_RR=0, STARVE_MAX=8 -> fetch issued after exactly 8 lost slots.
- ARB_RR=1, both requesting continuously -> grants alternate 0,1,0,1.
- Error on LSU transfer (s_hresp_i=1 for 2 cycles) while fetch pending -> s_hresp_o[0]=1 both cycles, s_hresp_o[1]=0; fetch issues afterwards.
- s_rst_i asserted while a transfer is pending -> next cycle s_htrans_o=IDLE, s_hready_o={1,1}, pend_v cleared.
